dds_phase_gen: RTL and testbench

Phase-accumulator (NCO) front end for the 2048-entry sine lookup stage. Each enabled cycle it adds a frequency tuning word (FTW) to an accumulator, applies a phase offset, and drives the truncated phase as the lookup read address. It accepts FTW updates through a valid/ready handshake, either immediately or phase-coherently at accumulator wrap. It also emits a valid flag delayed to line up with the lookup's registered output.

---
 rtl/dds_phase_gen.sv | 144 ++++++++++++++
 tb/tb_dds_phase_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase accumulator (NCO) front end for a 2^ADDR_WIDTH sine lookup.
// Adds the active tuning word to the accumulator each enabled cycle, applies a
// left-aligned phase offset and drives the truncated phase as the lookup address.
// Tuning words arrive over valid/ready and are applied immediately or at wrap.
// Optional build macro PHASE_DITHER_EN adds LFSR dither below the truncation point.
module dds_phase_gen #(
   parameter int ACC_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 11,
   parameter int LUT_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  phase_clr,
   input  logic                  upd_on_wrap,
   input  logic [ACC_WIDTH-1:0]  ftw_in,
   input  logic                  ftw_valid,
   output logic                  ftw_ready,
   input  logic [15:0]           phase_off,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  addr_valid,
   output logic                  wrap,
   output logic                  sample_valid
);

   logic [ACC_WIDTH-1:0]   acc_reg;
   logic [ACC_WIDTH-1:0]   ftw_active_reg;
   logic [ACC_WIDTH-1:0]   ftw_pend_reg;
   logic                   pend_reg;
   logic                   wrap_pend_reg;
   logic [LUT_LATENCY-1:0] pipe_reg;

   logic [ACC_WIDTH:0]     acc_sum;
   logic                   carry;
   logic                   wrap_evt;
   logic                   transfer;
   logic [ACC_WIDTH-1:0]   off_ext;
   logic [ACC_WIDTH-1:0]   phase_sum;
   logic [ADDR_WIDTH-1:0]  addr_next;

   // Extra bit catches the accumulator carry-out.
   assign acc_sum  = {1'b0, acc_reg} + {1'b0, ftw_active_reg};
   assign carry    = acc_sum[ACC_WIDTH];
   // A clear overrides the increment, so its carry is not a real wrap.
   assign wrap_evt = en & carry & ~phase_clr;
   // Pending word moves to active next edge, or only on a wrap edge when coherent.
   assign transfer  = pend_reg & (upd_on_wrap ? wrap_evt : 1'b1);
   assign ftw_ready = ~pend_reg;
   assign off_ext   = ACC_WIDTH'(phase_off) << (ACC_WIDTH - 16);

`ifdef PHASE_DITHER_EN
   localparam int DITH_W = ((ACC_WIDTH - ADDR_WIDTH) > 16) ? 16 : (ACC_WIDTH - ADDR_WIDTH);
   localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

   logic [15:0] lfsr_reg;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[14] ^ lfsr_reg[12] ^ lfsr_reg[3];

   // Maximal-length LFSR (taps 16,15,13,4), stepped once per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr_reg <= 16'hACE1;
      else if (en)
         lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
   end

   assign phase_sum = acc_reg + off_ext + ACC_WIDTH'(lfsr_reg & DITH_MASK);
`else
   assign phase_sum = acc_reg + off_ext;
`endif

   assign addr_next = ADDR_WIDTH'(phase_sum >> (ACC_WIDTH - ADDR_WIDTH));

   // Accumulator: clear has priority, otherwise advance only while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_reg <= '0;
      else if (phase_clr)
         acc_reg <= '0;
      else if (en)
         acc_reg <= acc_sum[ACC_WIDTH-1:0];
   end

   // Address path; wrap is held until the first sample taken after the carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr          <= '0;
         addr_valid    <= 1'b0;
         wrap          <= 1'b0;
         wrap_pend_reg <= 1'b0;
      end else begin
         addr_valid <= en;
         wrap       <= en & wrap_pend_reg;
         if (en)
            addr <= addr_next;
         if (wrap_evt)
            wrap_pend_reg <= 1'b1;
         else if (en)
            wrap_pend_reg <= 1'b0;
      end
   end

   // FTW handshake: single holding register, transfer wins over a new accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ftw_active_reg <= '0;
         ftw_pend_reg   <= '0;
         pend_reg       <= 1'b0;
      end else if (transfer) begin
         ftw_active_reg <= ftw_pend_reg;
         pend_reg       <= 1'b0;
      end else if (ftw_valid && !pend_reg) begin
         ftw_pend_reg <= ftw_in;
         pend_reg     <= 1'b1;
      end
   end

   // Valid delay line matching the lookup latency; keeps shifting while idle.
   generate
      for (genvar gi = 0; gi < LUT_LATENCY; gi++) begin : g_pipe
         if (gi == 0) begin : g_first
            // First stage samples addr_valid.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  pipe_reg[0] <= 1'b0;
               else
                  pipe_reg[0] <= addr_valid;
            end
         end else begin : g_rest
            // Later stages shift the previous stage.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  pipe_reg[gi] <= 1'b0;
               else
                  pipe_reg[gi] <= pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign sample_valid = pipe_reg[LUT_LATENCY-1];

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed checks of dds_phase_gen with default parameters
// (32-bit accumulator, 11-bit address, 3-cycle lookup latency).
module tb_dds_phase_gen;

   localparam int AW = 32;
   localparam int DW = 11;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          phase_clr;
   logic          upd_on_wrap;
   logic [AW-1:0] ftw_in;
   logic          ftw_valid;
   logic          ftw_ready;
   logic [15:0]   phase_off;
   logic [DW-1:0] addr;
   logic          addr_valid;
   logic          wrap;
   logic          sample_valid;

   int vec_cnt = 0;
   int err_cnt = 0;

   dds_phase_gen #(.ACC_WIDTH(AW), .ADDR_WIDTH(DW), .LUT_LATENCY(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .phase_clr    (phase_clr),
      .upd_on_wrap  (upd_on_wrap),
      .ftw_in       (ftw_in),
      .ftw_valid    (ftw_valid),
      .ftw_ready    (ftw_ready),
      .phase_off    (phase_off),
      .addr         (addr),
      .addr_valid   (addr_valid),
      .wrap         (wrap),
      .sample_valid (sample_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b0; phase_clr = 1'b0; upd_on_wrap = 1'b0;
      ftw_in = '0; ftw_valid = 1'b0; phase_off = 16'h0;
      #1 rst_n = 1'b0;
      tick; tick;
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_addr_valid", 32'(addr_valid), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_sample_valid", 32'(sample_valid), 32'd0);
      chk("rst_ftw_ready", 32'(ftw_ready), 32'd1);
      rst_n = 1'b1;
      tick;

      // Load step-1 FTW immediately while idle.
      ftw_in = 32'h0020_0000; ftw_valid = 1'b1;
      tick;
      chk("load_ready_low", 32'(ftw_ready), 32'd0);
      ftw_valid = 1'b0;
      tick;
      chk("load_ready_high", 32'(ftw_ready), 32'd1);

      // Ramp 0..2047, then wrap pulse on addr 0.
      en = 1'b1;
      for (int i = 0; i < 2048; i++) begin
         tick;
         chk("ramp_addr", 32'(addr), 32'(i));
         chk("ramp_wrap", 32'(wrap), 32'd0);
         if (i < 4)
            chk("sv_latency", 32'(sample_valid), (i >= 3) ? 32'd1 : 32'd0);
      end
      tick;
      chk("wrap_addr", 32'(addr), 32'd0);
      chk("wrap_pulse", 32'(wrap), 32'd1);
      tick;
      chk("post_wrap_addr", 32'(addr), 32'd1);
      chk("post_wrap_pulse", 32'(wrap), 32'd0);

      // Quarter-turn offset: addr = acc index + 512; wrap still follows acc.
      phase_off = 16'h4000;
      for (int i = 0; i < 2048; i++) begin
         int idx;
         idx = (i + 2) % 2048;
         tick;
         chk("off_addr", 32'(addr), 32'((idx + 512) % 2048));
         chk("off_wrap", 32'(wrap), (idx == 0) ? 32'd1 : 32'd0);
      end
      phase_off = 16'h0;

      // Coherent update: step-2 word waits for the wrap.
      upd_on_wrap = 1'b1;
      ftw_in = 32'h0040_0000; ftw_valid = 1'b1;
      tick;
      chk("coh_accept_addr", 32'(addr), 32'd2);
      chk("coh_accept_ready", 32'(ftw_ready), 32'd0);
      ftw_valid = 1'b0;
      for (int k = 3; k < 2048; k++) begin
         tick;
         chk("coh_addr", 32'(addr), 32'(k));
         chk("coh_ready", 32'(ftw_ready), (k == 2047) ? 32'd1 : 32'd0);
      end
      tick;
      chk("coh_wrap_addr", 32'(addr), 32'd0);
      chk("coh_wrap", 32'(wrap), 32'd1);
      tick;
      chk("coh_step2_a", 32'(addr), 32'd2);
      tick;
      chk("coh_step2_b", 32'(addr), 32'd4);

      // Word offered on the wrap edge itself stays pending a full period.
      for (int k = 3; k <= 1022; k++) begin
         tick;
         chk("same_pre_addr", 32'(addr), 32'(2 * k));
      end
      ftw_in = 32'h0020_0000; ftw_valid = 1'b1;
      tick;
      chk("same_edge_addr", 32'(addr), 32'd2046);
      chk("same_edge_ready", 32'(ftw_ready), 32'd0);
      ftw_valid = 1'b0;
      tick;
      chk("same_wrap_addr", 32'(addr), 32'd0);
      chk("same_wrap", 32'(wrap), 32'd1);
      for (int k = 1; k <= 1023; k++) begin
         tick;
         chk("same_hold_addr", 32'(addr), 32'(2 * k));
         chk("same_hold_ready", 32'(ftw_ready), (k == 1023) ? 32'd1 : 32'd0);
      end
      tick;
      chk("same_wrap2_addr", 32'(addr), 32'd0);
      chk("same_wrap2", 32'(wrap), 32'd1);
      tick;
      chk("same_step1_a", 32'(addr), 32'd1);
      tick;
      chk("same_step1_b", 32'(addr), 32'd2);

      // Clear issued with addr=100: next address is 0, no wrap.
      for (int k = 3; k <= 99; k++) begin
         tick;
         chk("clr_pre_addr", 32'(addr), 32'(k));
      end
      phase_clr = 1'b1;
      tick;
      chk("clr_at_addr", 32'(addr), 32'd100);
      phase_clr = 1'b0;
      tick;
      chk("clr_next_addr", 32'(addr), 32'd0);
      chk("clr_no_wrap", 32'(wrap), 32'd0);
      tick;
      chk("clr_addr1", 32'(addr), 32'd1);
      chk("clr_no_wrap2", 32'(wrap), 32'd0);

      // Idle for 5 cycles: valid drops, sample_valid drains 3 cycles later.
      en = 1'b0;
      for (int t = 1; t <= 5; t++) begin
         tick;
         chk("idle_addr_valid", 32'(addr_valid), 32'd0);
         chk("idle_sample_valid", 32'(sample_valid), (t <= 3) ? 32'd1 : 32'd0);
      end
      en = 1'b1;
      tick;
      chk("resume_addr", 32'(addr), 32'd2);
      chk("resume_addr_valid", 32'(addr_valid), 32'd1);
      chk("resume_sample_valid", 32'(sample_valid), 32'd0);

      // Asynchronous reset with a word pending.
      ftw_in = 32'h0040_0000; ftw_valid = 1'b1;
      tick;
      chk("pend_ready", 32'(ftw_ready), 32'd0);
      ftw_valid = 1'b0;
      tick;
      chk("pend_hold_ready", 32'(ftw_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_addr", 32'(addr), 32'd0);
      chk("arst_addr_valid", 32'(addr_valid), 32'd0);
      chk("arst_wrap", 32'(wrap), 32'd0);
      chk("arst_sample_valid", 32'(sample_valid), 32'd0);
      chk("arst_ftw_ready", 32'(ftw_ready), 32'd1);
      tick;
      rst_n = 1'b1;
      phase_off = 16'h4000;
      tick;
      chk("rel_addr", 32'(addr), 32'd512);
      chk("rel_ready", 32'(ftw_ready), 32'd1);
      chk("rel_sv1", 32'(sample_valid), 32'd0);
      tick;
      chk("rel_addr_hold", 32'(addr), 32'd512);
      chk("rel_sv2", 32'(sample_valid), 32'd0);
      tick;
      chk("rel_sv3", 32'(sample_valid), 32'd0);
      tick;
      chk("rel_sv4", 32'(sample_valid), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
